// File: rtl/shift_sched_if.sv
// Request/grant/result bundle between two shift-job requesters and the shared
// shift scheduler.
interface shift_sched_if;
  logic       req0;
  logic [3:0] d0;
  logic       dir0;
  logic [2:0] cnt0;
  logic       req1;
  logic [3:0] d1;
  logic       dir1;
  logic [2:0] cnt1;
  logic       gnt0;
  logic       gnt1;
  logic       busy;
  logic [3:0] q;
  logic       done0;
  logic       done1;

  modport master (
    output req0, d0, dir0, cnt0,
    output req1, d1, dir1, cnt1,
    input  gnt0, gnt1, busy, q, done0, done1
  );

  modport slave (
    input  req0, d0, dir0, cnt0,
    input  req1, d1, dir1, cnt1,
    output gnt0, gnt1, busy, q, done0, done1
  );
endinterface

// File: rtl/shift_sched.sv
// Round-robin scheduler that runs shift jobs from two requesters on one shared
// one-bit-per-cycle shifter, publishing each result in q with a done strobe.
module shift_sched (
  input  logic          clk,
  input  logic          rst,
  shift_sched_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] work_q, work_d;
  logic [3:0] q_q, q_d;
  logic [2:0] remain_q, remain_d;
  logic       dir_q, dir_d;
  logic       owner_q, owner_d;
  logic       lastGnt_q, lastGnt_d;

  logic       grant;
  logic       winner;
  logic [3:0] winData;
  logic       winDir;
  logic [2:0] winCnt;
  logic       shL;
  logic       shR;
  logic [3:0] shOut;

  // Grant is gated by rst so no strobe escapes while reset is held.
  always_comb begin
    grant  = 1'b0;
    winner = 1'b0;
    if (state_q == IDLE && !rst) begin
      if (bus.req0 && bus.req1) begin
        grant  = 1'b1;
        winner = ~lastGnt_q;
      end else if (bus.req0) begin
        grant  = 1'b1;
        winner = 1'b0;
      end else if (bus.req1) begin
        grant  = 1'b1;
        winner = 1'b1;
      end
    end
  end

  assign winData = winner ? bus.d1   : bus.d0;
  assign winDir  = winner ? bus.dir1 : bus.dir0;
  assign winCnt  = winner ? bus.cnt1 : bus.cnt0;

  assign shL = (state_q == SHIFT) &&  dir_q;
  assign shR = (state_q == SHIFT) && !dir_q;

  always_comb begin
    shOut = work_q;
    if (shL) begin
      shOut = {work_q[2:0], 1'b0};
    end else if (shR) begin
      shOut = {1'b0, work_q[3:1]};
    end
  end

  always_comb begin
    state_d   = state_q;
    work_d    = work_q;
    q_d       = q_q;
    remain_d  = remain_q;
    dir_d     = dir_q;
    owner_d   = owner_q;
    lastGnt_d = lastGnt_q;
    unique case (state_q)
      IDLE: begin
        if (grant) begin
          work_d    = winData;
          dir_d     = winDir;
          remain_d  = winCnt;
          owner_d   = winner;
          lastGnt_d = winner;
          if (winCnt != 3'd0) begin
            state_d = SHIFT;
          end else begin
            state_d = DONE;
            q_d     = winData;
          end
        end
      end
      SHIFT: begin
        work_d   = shOut;
        remain_d = remain_q - 3'd1;
        if (remain_q == 3'd1) begin
          state_d = DONE;
          q_d     = shOut;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      work_q    <= 4'd0;
      q_q       <= 4'd0;
      remain_q  <= 3'd0;
      dir_q     <= 1'b0;
      owner_q   <= 1'b0;
      lastGnt_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      work_q    <= work_d;
      q_q       <= q_d;
      remain_q  <= remain_d;
      dir_q     <= dir_d;
      owner_q   <= owner_d;
      lastGnt_q <= lastGnt_d;
    end
  end

  assign bus.gnt0  = grant & ~winner;
  assign bus.gnt1  = grant &  winner;
  assign bus.busy  = (state_q != IDLE);
  assign bus.q     = q_q;
  assign bus.done0 = (state_q == DONE) & ~owner_q;
  assign bus.done1 = (state_q == DONE) &  owner_q;

endmodule

// File: doc/shift_sched.md
SHIFT_SCHED -- requirements
Module: shift_sched

Interface
REQ-001 Parameters: none; datapath width fixed at 4 bits, shift count fixed at 3 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req0  input  1  requester 0 asks for a shift job; held high until gnt0 is seen.
REQ-005 d0  input  4  requester 0 operand.
REQ-006 dir0  input  1  requester 0 direction: 1 = left (toward bit 3), 0 = right.
REQ-007 cnt0  input  3  requester 0 shift count, 0..7.
REQ-008 req1, d1, dir1, cnt1  input  1/4/1/3  requester 1, same meaning as REQ-004..007.
REQ-009 gnt0, gnt1  output  1  acceptance strobe for the job sampled at this clock edge.
REQ-010 busy  output  1  high whenever a job is in progress (state not IDLE).
REQ-011 q  output  4  result register.
REQ-012 done0, done1  output  1  one-cycle strobe: q holds the owning requester's result.

Function
REQ-013 Shared datapath: one 4-bit one-step shifter with controls l, r; l=1,r=0: o = {i[2:0],0}; l=0,r=1: o = {0,i[3:1]}; l=r=0: o = i; block SHALL never drive l=r=1.
REQ-014 FSM states IDLE, SHIFT, DONE; one-hot or binary encoding is free.
REQ-015 IDLE: gnt0/gnt1 are combinational from state and requests; at most one high; both low outside IDLE.
REQ-016 Arbitration in IDLE: single requester wins; if both request, the one not granted last wins (round-robin); last-grant pointer updates only on a grant.
REQ-017 Grant edge: capture winner's d into work register, dir and cnt into job registers, owner id; go to SHIFT if cnt != 0, else DONE.
REQ-018 SHIFT: each cycle work <= shifter(work) with l = dir, r = !dir; remaining count decrements; transition to DONE on the edge where remaining goes 1 -> 0.
REQ-019 Entering DONE: q <= work (the fully shifted value).
REQ-020 DONE: exactly one cycle; done strobe of owner high, other done low; next state IDLE unconditionally.
REQ-021 Latency: grant at cycle c -> DONE (done strobe, q valid) at cycle c+cnt+1; minimum two cycles per job, no overlap between jobs.
REQ-022 q holds its value from DONE until the next DONE; it never changes in IDLE or SHIFT.
REQ-023 Counts 4..7 SHALL shift all bits out, giving q = 0000 (zero fill, no rotate).
REQ-024 Request inputs are ignored in SHIFT and DONE; deassertion of req mid-job does not abort the job.
REQ-025 Request inputs changing in the grant cycle affect only arbitration of that cycle; captured values are those present at the grant edge.
REQ-026 busy = (state != IDLE); low in the cycle after DONE.

Reset
REQ-027 rst high SHALL immediately force: state IDLE, q = 0000, busy 0, gnt0/gnt1/done0/done1 0, remaining count 0, last-grant pointer = requester 1 (so requester 0 wins the first tie).
REQ-028 Reset during SHIFT or DONE SHALL abort the job with no done strobe; job is not resumed after reset release.
REQ-029 First grant possible in the first IDLE cycle after rst deasserts.

Verification
REQ-030 req0, d0=0110, dir0=1, cnt0=1 -> gnt0 at cycle c, done0 at c+2, q=1100, busy high c+1..c+2.
REQ-031 req1, d1=1011, dir1=0, cnt1=2 -> gnt1 at c, done1 at c+3, q=0010; done0 stays 0.
REQ-032 req0, d0=1001, cnt0=0 -> gnt0 at c, done0 at c+1, q=1001, no SHIFT cycle.
REQ-033 After reset, req0 and req1 held high continuously (cnt=0) -> grant order 0,1,0,1; one grant per two cycles.
REQ-034 req0, d0=1111, dir0=1, cnt0=7 -> done0 at c+8, q=0000.
REQ-035 Job d0=1111, cnt0=5 running; rst pulsed at c+2 -> busy, done0 low immediately, q=0000, no done strobe after release; next req0 granted normally.
